// File: rtl/y_row_line_fetcher.sv
// Row-number to Y-memory line-address fetcher: looks up a row's base line in the
// packed row-index table and streams LINES consecutive line addresses.
module y_row_line_fetcher #(
    parameter int unsigned ROW_W   = 16,
    parameter int unsigned MEM_W   = 256,
    parameter int unsigned ENTRY_W = 16,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned IDX_AW  = 12,
    parameter int unsigned LINES   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ROW_W-1:0]  req_row,
    input  logic              req_bypass,
    output logic              idx_rd_en,
    output logic [IDX_AW-1:0] idx_rd_addr,
    input  logic [MEM_W-1:0]  idx_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_done,
    output logic              busy
);

    localparam int unsigned EPW   = MEM_W / ENTRY_W;
    localparam int unsigned SEL_W = $clog2(EPW);
    localparam int unsigned K_W   = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_IDX_RD   = 3'd1;
    localparam logic [2:0] S_IDX_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [K_W-1:0] K_LAST = K_W'(LINES - 1);

    logic [2:0]        state,       state_n;
    logic [SEL_W-1:0]  sel,         sel_n;
    logic [K_W-1:0]    k,           k_n;
    logic              req_ready_n;
    logic              idx_rd_en_n;
    logic [IDX_AW-1:0] idx_rd_addr_n;
    logic              out_valid_n;
    logic [ADDR_W-1:0] out_addr_n;
    logic              out_last_n;
    logic              out_done_n;
    logic              busy_n;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n       = state;
        sel_n         = sel;
        k_n           = k;
        req_ready_n   = req_ready;
        idx_rd_en_n   = 1'b0;
        idx_rd_addr_n = idx_rd_addr;
        out_valid_n   = out_valid;
        out_addr_n    = out_addr;
        out_last_n    = out_last;
        out_done_n    = 1'b0;
        busy_n        = busy;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    req_ready_n = 1'b0;
                    busy_n      = 1'b1;
                    // Bypass is checked before the sentinel so an all-ones direct address still emits.
                    if (req_bypass) begin
                        state_n     = S_EMIT;
                        out_valid_n = 1'b1;
                        out_addr_n  = req_row[ADDR_W-1:0];
                        out_last_n  = 1'b1;
                        k_n         = '0;
                    end else if (&req_row) begin
                        state_n    = S_DONE;
                        out_done_n = 1'b1;
                    end else begin
                        state_n       = S_IDX_RD;
                        idx_rd_en_n   = 1'b1;
                        idx_rd_addr_n = IDX_AW'(req_row >> SEL_W);
                        sel_n         = req_row[SEL_W-1:0];
                    end
                end
            end

            S_IDX_RD: begin
                state_n = S_IDX_WAIT;
            end

            S_IDX_WAIT: begin
                state_n     = S_EMIT;
                out_valid_n = 1'b1;
                out_addr_n  = idx_rd_data[sel*ENTRY_W +: ADDR_W];
                out_last_n  = (LINES == 1);
                k_n         = '0;
            end

            S_EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_n     = S_IDLE;
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        req_ready_n = 1'b1;
                        busy_n      = 1'b0;
                    end else begin
                        // Address arithmetic wraps naturally at 2^ADDR_W.
                        k_n        = k + K_W'(1);
                        out_addr_n = out_addr + ADDR_W'(1);
                        out_last_n = (k_n == K_LAST);
                    end
                end
            end

            S_DONE: begin
                state_n     = S_IDLE;
                req_ready_n = 1'b1;
                busy_n      = 1'b0;
            end

            default: begin
                state_n     = S_IDLE;
                out_valid_n = 1'b0;
                out_last_n  = 1'b0;
                req_ready_n = 1'b1;
                busy_n      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            sel         <= '0;
            k           <= '0;
            req_ready   <= 1'b1;
            idx_rd_en   <= 1'b0;
            idx_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '1;
            out_last    <= 1'b0;
            out_done    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            k           <= k_n;
            req_ready   <= req_ready_n;
            idx_rd_en   <= idx_rd_en_n;
            idx_rd_addr <= idx_rd_addr_n;
            out_valid   <= out_valid_n;
            out_addr    <= out_addr_n;
            out_last    <= out_last_n;
            out_done    <= out_done_n;
            busy        <= busy_n;
        end
    end

endmodule
